buffer_m_writer: RTL and testbench

Writable counterpart of the per-PE model buffer. It accepts a stream of words from the memory interface, keeps only the words tagged with its own PE id, and writes them into an internal RAM at sequential addresses starting from a programmed base. It presents the same registered read port to the PE datapath: `rd_addr` in, `data_out` one cycle later. One instance sits beside each PE, and all instances share the write stream.

---
 rtl/buffer_m_writer.sv | 156 +++++++++++++++
 tb/tb_buffer_m_writer.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/buffer_m_writer.sv
// buffer_m_writer
// Writable per-PE model buffer. Filters a shared write stream by PE id and
// stores matching words at sequential addresses from a programmed base.
// Registered read port: rd_addr on cycle N -> data_out during N+1.
//
// Optional feature macro: BUFFERM_WR_BYPASS_EN
//   defined   : a same-cycle matching write and read of the same address
//               forwards wr_data to data_out on the next cycle.
//   undefined : the collision returns the old RAM word (no bypass mux).
//
// Stream handshake: a word transfers on every rising edge where
// wr_valid && wr_ready. wr_ready is high for the whole LOAD state and does
// not depend on wr_valid or wr_pe_id, so foreign words are consumed and
// dropped without ever stalling the shared stream.
module buffer_m_writer #(
   parameter int addrLen = 10,
   parameter int dataLen = 32,
   parameter int peId    = 0
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               load_start,
   input  logic [addrLen-1:0] load_base,
   input  logic [addrLen:0]   load_count,
   input  logic               wr_valid,
   output logic               wr_ready,
   input  logic [dataLen-1:0] wr_data,
   input  logic [5:0]         wr_pe_id,
   output logic               busy,
   output logic               load_done,
   output logic               wrap_err,
   input  logic [addrLen-1:0] rd_addr,
   output logic [dataLen-1:0] data_out,
   output logic [1:0]         dbg_state
);

   localparam int                 DEPTH    = 1 << addrLen;
   localparam logic [5:0]         PE_ID    = 6'(peId);
   localparam logic [addrLen-1:0] PTR_LAST = {addrLen{1'b1}};
   localparam logic [addrLen:0]   REM_ONE  = (addrLen+1)'(1);
   localparam logic [addrLen:0]   REM_ZERO = '0;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t               r_state;
   state_t               w_state_nxt;
   logic [addrLen-1:0]   r_wr_ptr;
   logic [addrLen:0]     r_remaining;
   logic                 r_wrap_err;
   logic [dataLen-1:0]   r_data_out;
   logic [dataLen-1:0]   r_mem [0:DEPTH-1];

   logic                 w_match;
   logic                 w_accept;
   logic                 w_wr_en;
   logic                 w_last_wr;
   logic [dataLen-1:0]   w_rd_word;

   assign w_match   = (wr_pe_id == PE_ID);
   // The final matching write of a load; its pointer increment never counts as a wrap.
   assign w_last_wr = (r_remaining == REM_ONE);

   // State register; reset aborts any load in flight.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state and control outputs, all decoded from the current state.
   always_comb begin
      w_state_nxt = r_state;
      w_accept    = 1'b0;
      w_wr_en     = 1'b0;
      wr_ready    = 1'b0;
      busy        = 1'b0;
      load_done   = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (load_start) begin
               w_accept    = 1'b1;
               w_state_nxt = (load_count == REM_ZERO) ? ST_DONE : ST_LOAD;
            end
         end
         ST_LOAD: begin
            wr_ready = 1'b1;
            busy     = 1'b1;
            if (wr_valid && w_match) begin
               w_wr_en = 1'b1;
               if (w_last_wr) begin
                  w_state_nxt = ST_DONE;
               end
            end
         end
         ST_DONE: begin
            load_done   = 1'b1;
            w_state_nxt = ST_IDLE;
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // Write pointer, remaining count and sticky wrap flag.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_wr_ptr    <= '0;
         r_remaining <= '0;
         r_wrap_err  <= 1'b0;
      end else if (w_accept) begin
         r_wr_ptr    <= load_base;
         r_remaining <= load_count;
         r_wrap_err  <= 1'b0;
      end else if (w_wr_en) begin
         r_wr_ptr    <= r_wr_ptr + 1'b1;
         r_remaining <= r_remaining - REM_ONE;
         if (r_wr_ptr == PTR_LAST && !w_last_wr) begin
            r_wrap_err <= 1'b1;
         end
      end
   end

   // RAM write port; contents are deliberately not reset.
   always_ff @(posedge clk) begin
      if (w_wr_en) begin
         r_mem[r_wr_ptr] <= wr_data;
      end
   end

`ifdef BUFFERM_WR_BYPASS_EN
   assign w_rd_word = (w_wr_en && (r_wr_ptr == rd_addr)) ? wr_data : r_mem[rd_addr];
`else
   assign w_rd_word = r_mem[rd_addr];
`endif

   // Registered read port, active in every FSM state.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_data_out <= '0;
      end else begin
         r_data_out <= w_rd_word;
      end
   end

   assign data_out  = r_data_out;
   assign wrap_err  = r_wrap_err;
   assign dbg_state = r_state;

endmodule

// File: tb/tb_buffer_m_writer.sv
// Bench for buffer_m_writer (addrLen=6, dataLen=32, peId=3).
// Reference model: a word array plus a transaction-level view of the current
// load (base, count, words stored so far). Write addresses are computed as
// (base + k) mod depth; read expectations go through exp_q.
module tb_buffer_m_writer;

   localparam int AW    = 6;
   localparam int DW    = 32;
   localparam int PE    = 3;
   localparam int DEPTH = 1 << AW;

   // ---------------- clock / reset ----------------
   logic          clk = 1'b0;
   logic          reset_n;
   logic          load_start = 1'b0;
   logic [AW-1:0] load_base  = '0;
   logic [AW:0]   load_count = '0;
   logic          wr_valid   = 1'b0;
   logic [DW-1:0] wr_data    = '0;
   logic [5:0]    wr_pe_id   = '0;
   logic [AW-1:0] rd_addr    = '0;
   logic          wr_ready;
   logic          busy;
   logic          load_done;
   logic          wrap_err;
   logic [DW-1:0] data_out;
   logic [1:0]    dbg_state;

   always #5 clk = ~clk;

   buffer_m_writer #(.addrLen(AW), .dataLen(DW), .peId(PE)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .load_start (load_start),
      .load_base  (load_base),
      .load_count (load_count),
      .wr_valid   (wr_valid),
      .wr_ready   (wr_ready),
      .wr_data    (wr_data),
      .wr_pe_id   (wr_pe_id),
      .busy       (busy),
      .load_done  (load_done),
      .wrap_err   (wrap_err),
      .rd_addr    (rd_addr),
      .data_out   (data_out),
      .dbg_state  (dbg_state)
   );

   // ---------------- reference model ----------------
   logic [DW-1:0] mem_m [DEPTH];
   bit            known_m [DEPTH];
   int            m_phase;   // 0 idle, 1 loading, 2 done pulse
   int            m_base;
   int            m_cnt;
   int            m_k;
   bit            m_wrap;
   logic [DW-1:0] exp_q [$];
   bit            expk_q [$];
   int            n_vec = 0;
   int            n_err = 0;

   // ---------------- scoreboard check ----------------
   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // ---------------- driver: one clock cycle ----------------
   // Entered and left at a falling edge. Checks the outputs of the current
   // cycle, drives the inputs, then advances the model across the rising edge.
   task automatic step(input bit ld, input int b, input int c, input bit v,
                       input int id, input logic [DW-1:0] d, input int ra);
      int            addr;
      bit            wr;
      logic [DW-1:0] e;
      bit            k;
      check("busy",      {63'd0, busy},      {63'd0, m_phase == 1});
      check("wr_ready",  {63'd0, wr_ready},  {63'd0, m_phase == 1});
      check("load_done", {63'd0, load_done}, {63'd0, m_phase == 2});
      check("wrap_err",  {63'd0, wrap_err},  {63'd0, m_wrap});
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         k = expk_q.pop_front();
         if (k) check("data_out", {32'd0, data_out}, {32'd0, e});
      end
      load_start = ld;
      load_base  = AW'(b);
      load_count = (AW+1)'(c);
      wr_valid   = v;
      wr_pe_id   = 6'(id);
      wr_data    = d;
      rd_addr    = AW'(ra);
      @(posedge clk);
      wr   = (m_phase == 1) && v && (id == PE);
      addr = (m_base + m_k) % DEPTH;
`ifdef BUFFERM_WR_BYPASS_EN
      if (wr && addr == ra) begin
         exp_q.push_back(d);
         expk_q.push_back(1'b1);
      end else begin
         exp_q.push_back(mem_m[ra]);
         expk_q.push_back(known_m[ra]);
      end
`else
      exp_q.push_back(mem_m[ra]);
      expk_q.push_back(known_m[ra]);
`endif
      case (m_phase)
         0: if (ld) begin
               m_base  = b;
               m_cnt   = c;
               m_k     = 0;
               m_wrap  = 1'b0;
               m_phase = (c == 0) ? 2 : 1;
            end
         1: if (wr) begin
               mem_m[addr]   = d;
               known_m[addr] = 1'b1;
               m_k++;
               if (addr == DEPTH - 1 && m_k < m_cnt) m_wrap = 1'b1;
               if (m_k == m_cnt) m_phase = 2;
            end
         default: m_phase = 0;
      endcase
      @(negedge clk);
   endtask

   task automatic idle(input int ra);
      step(1'b0, 0, 0, 1'b0, 0, '0, ra);
   endtask

   task automatic word(input int id, input logic [DW-1:0] d);
      step(1'b0, 0, 0, 1'b1, id, d, 0);
   endtask

   task automatic start(input int b, input int c);
      step(1'b1, b, c, 1'b0, 0, '0, 0);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int budget;
      int c;
      int r;
      m_phase = 0; m_base = 0; m_cnt = 0; m_k = 0; m_wrap = 1'b0;
      for (int i = 0; i < DEPTH; i++) known_m[i] = 1'b0;

      reset_n = 1'b1;
      #2 reset_n = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_busy",     {63'd0, busy},      64'd0);
      check("rst_wr_ready", {63'd0, wr_ready},  64'd0);
      check("rst_done",     {63'd0, load_done}, 64'd0);
      check("rst_wrap",     {63'd0, wrap_err},  64'd0);
      check("rst_data_out", {32'd0, data_out},  64'd0);
      reset_n = 1'b1;
      exp_q.push_back('0);
      expk_q.push_back(1'b1);

      // Basic load: base 0x10, four words 0xA0..0xA3
      start(16, 4);
      for (int i = 0; i < 4; i++) word(PE, 32'hA0 + i);
      idle(16); idle(17); idle(18); idle(19); idle(0);

      // Interleaved ids 5,3,7,3 with data 1..4, only 2 and 4 kept
      start(32, 2);
      word(5, 1); word(PE, 2); word(7, 3); word(PE, 4);
      idle(32); idle(33); idle(0);

      // Wrap: base 62, count 4 -> 62, 63, 0, 1
      start(62, 4);
      for (int i = 0; i < 4; i++) word(PE, 32'hC0 + i);
      idle(62); idle(63); idle(0); idle(1); idle(0);

      // Zero count clears wrap_err and only pulses load_done
      start(40, 0);
      idle(0); idle(0); idle(0);

      // load_start during LOAD is ignored
      start(20, 2);
      word(PE, 32'hD0);
      step(1'b1, 45, 9, 1'b1, PE, 32'hD1, 0);
      idle(20); idle(21); idle(0);

      // Collision: mem[7]=0x11, then write 0x55 to 7 while reading 7
      start(7, 1);
      word(PE, 32'h11);
      idle(7); idle(7);
      start(7, 1);
      step(1'b0, 0, 0, 1'b1, PE, 32'h55, 7);
      idle(7); idle(7);

      // Full-depth loads: base 0 must not wrap, base 5 must
      start(0, DEPTH);
      for (int i = 0; i < DEPTH; i++) word(PE, $urandom);
      idle(0); idle(63); idle(0);
      start(5, DEPTH);
      for (int i = 0; i < DEPTH; i++) word(PE, $urandom);
      idle(4); idle(5); idle(0);

      // Randomised loads with foreign ids, gaps, ignored starts and live reads
      for (int n = 0; n < 30; n++) begin
         r = $urandom_range(0, 19);
         c = (r < 2) ? 0 : (r < 4) ? DEPTH : $urandom_range(1, 12);
         step(1'b1, $urandom_range(0, DEPTH - 1), c, 1'b0, 0, '0, $urandom_range(0, DEPTH - 1));
         budget = 0;
         while (m_phase != 0 && budget < 1000) begin
            step($urandom_range(0, 9) == 0, $urandom_range(0, DEPTH - 1), $urandom_range(0, 20),
                 $urandom_range(0, 3) != 0,
                 ($urandom_range(0, 2) == 0) ? $urandom_range(0, 63) : PE,
                 $urandom, $urandom_range(0, DEPTH - 1));
            budget++;
         end
         if (budget >= 1000) check("load_timeout", 64'(m_phase), 64'd0);
         for (int i = 0; i < 3; i++) idle($urandom_range(0, DEPTH - 1));
      end

      // Reset mid-load: base 10, count 5, reset after 2 words
      start(10, 5);
      word(PE, 32'hB0);
      word(PE, 32'hB1);
      reset_n = 1'b0;
      #1;
      check("abort_busy",     {63'd0, busy},      64'd0);
      check("abort_wr_ready", {63'd0, wr_ready},  64'd0);
      check("abort_done",     {63'd0, load_done}, 64'd0);
      check("abort_wrap",     {63'd0, wrap_err},  64'd0);
      check("abort_data_out", {32'd0, data_out},  64'd0);
      @(negedge clk);
      reset_n = 1'b1;
      m_phase = 0;
      m_wrap  = 1'b0;
      exp_q.delete();
      expk_q.delete();
      exp_q.push_back('0);
      expk_q.push_back(1'b1);
      idle(0); idle(0); idle(10); idle(11); idle(12); idle(0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   // Absolute time bound on the whole run
   initial begin
      #2000000;
      $display("FAIL watchdog: run did not finish, %0d miscompares so far", n_err);
      $fatal(1, "watchdog");
   end

endmodule
